// File: rtl/aud_mixer_pkg.sv
// Shared constants and helpers for the audio mixer.
package aud_mixer_pkg;

    localparam int AUD_W_DEF = 4;
    localparam int OUT_W_DEF = 6;
    localparam int GAIN_W    = 2;
    localparam int SCALE_XW  = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/aud_add_stage.sv
// One registered pairwise-add level of the mixer adder tree.
module aud_add_stage
    import aud_mixer_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int IN_W = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_i,
    input  logic [N_IN*IN_W-1:0]           data_i,
    output logic                           valid_o,
    output logic [(N_IN/2)*(IN_W+1)-1:0]   data_o
);

    localparam int N_OUT = N_IN / 2;
    localparam int SW    = IN_W + 1;

    logic [N_OUT*SW-1:0] sum_d;
    logic [N_OUT*SW-1:0] sum_q;
    logic                vld_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            sum_d[k*SW +: SW] = SW'(data_i[(2*k)*IN_W +: IN_W])
                              + SW'(data_i[(2*k+1)*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            vld_q <= valid_i;
        end
    end

    assign data_o  = sum_q;
    assign valid_o = vld_q;

endmodule

// File: rtl/aud_mixer.sv
// Pipelined N-channel audio mixer: capture, adder tree, gain/saturate,
// peak hold and sticky clip.
module aud_mixer
    import aud_mixer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int AUD_W  = AUD_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enn,
    input  logic [NUM_CH*AUD_W-1:0] audIn,
    input  logic [NUM_CH-1:0]       chMute,
    input  logic [GAIN_W-1:0]       gainShift,
    input  logic                    peakClr,
    output logic [OUT_W-1:0]        audOut,
    output logic                    audValid,
    output logic [OUT_W-1:0]        peakOut,
    output logic                    clipSticky
);

    localparam int LEVELS = clog2(NUM_CH);
    localparam int PAD    = 1 << LEVELS;
    localparam int SUM_W  = AUD_W + LEVELS;
    localparam int SC_W   = SUM_W + SCALE_XW;
    localparam int EXT_W  = (SC_W > OUT_W) ? SC_W : OUT_W;

    // Bit offset of each tree level inside the flat level bus.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int j = 0; j < l; j++) o += (PAD >> j) * (AUD_W + j);
        return o;
    endfunction

    localparam int TOT_W = lvl_off(LEVELS + 1);

    logic [PAD*AUD_W-1:0] cap_d, cap_q;
    logic                 cap_vld_q;

    always_comb begin
        cap_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cap_d[k*AUD_W +: AUD_W] =
                chMute[k] ? '0 : audIn[k*AUD_W +: AUD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= enn;
            if (enn) cap_q <= cap_d;
        end
    end

    wire [TOT_W-1:0] tree_bus;
    wire [LEVELS:0]  tree_vld;

    assign tree_bus[PAD*AUD_W-1:0] = cap_q;
    assign tree_vld[0]             = cap_vld_q;

    for (genvar l = 0; l < LEVELS; l++) begin : g_tree
        localparam int NI = PAD >> l;
        localparam int IW = AUD_W + l;
        aud_add_stage #(
            .N_IN (NI),
            .IN_W (IW)
        ) u_add (
            .clk     (clk),
            .reset   (reset),
            .valid_i (tree_vld[l]),
            .data_i  (tree_bus[lvl_off(l) +: NI*IW]),
            .valid_o (tree_vld[l+1]),
            .data_o  (tree_bus[lvl_off(l+1) +: (NI/2)*(IW+1)])
        );
    end

    logic [SUM_W-1:0] sum;
    assign sum = tree_bus[lvl_off(LEVELS) +: SUM_W];

    logic [SC_W-1:0] sc_d, sc_q;
    logic            sc_vld_q;

    assign sc_d = SC_W'(sum) << gainShift;

    always_ff @(posedge clk) begin
        if (reset) begin
            sc_q     <= '0;
            sc_vld_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            sc_vld_q <= tree_vld[LEVELS];
        end
    end

    logic [EXT_W-1:0] ext;
    logic             sat;
    logic             clip_ev;
    logic [OUT_W-1:0] new_out;

    assign ext     = EXT_W'(sc_q);
    assign sat     = ext > EXT_W'({OUT_W{1'b1}});
    assign clip_ev = sc_vld_q & sat;
    assign new_out = sat ? {OUT_W{1'b1}} : ext[OUT_W-1:0];

    logic [OUT_W-1:0] out_d, out_q;
    logic [OUT_W-1:0] peak_d, peak_q;
    logic             vld_q;
    logic             clip_d, clip_q;

    always_comb begin
        out_d  = out_q;
        peak_d = peak_q;
        if (sc_vld_q) begin
            out_d = new_out;
            if (peakClr || (new_out > peak_q)) peak_d = new_out;
        end else if (peakClr) begin
            peak_d = '0;
        end
        // A clip in the same clk as peakClr still sets the flag.
        clip_d = clip_ev | (clip_q & ~peakClr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            vld_q  <= 1'b0;
            peak_q <= '0;
            clip_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            vld_q  <= sc_vld_q;
            peak_q <= peak_d;
            clip_q <= clip_d;
        end
    end

    assign audOut     = out_q;
    assign audValid   = vld_q;
    assign peakOut    = peak_q;
    assign clipSticky = clip_q;

endmodule
